// File: rtl/instr_fetch.sv
// Program-side front end: program memory, PC and instruction register.
// A fetched word is presented for exactly one EXEC cycle; a valid/ready port loads the program while halted.
module instr_fetch #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned PROGRAM_DataWidth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [PROGRAM_DataWidth-1:0] load_data,
  input  logic                         load_last,
  input  logic                         cnt_wr_en,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         halted
);

  localparam int unsigned Depth = 2 ** PC_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]                   r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]          r_pc, w_pc_nxt;
  logic [PC_WIDTH-1:0]          r_load_adr, w_load_adr_nxt;
  logic [PROGRAM_DataWidth-1:0] r_instr;
  logic                         w_mem_we;

  logic [PROGRAM_DataWidth-1:0] r_mem [Depth];

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_load_adr_nxt = r_load_adr;
    w_mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A load in the same cycle as run takes priority; execution starts once loading stops.
        if (load_valid) begin
          w_mem_we = 1'b1;
          if (load_last) begin
            w_load_adr_nxt = '0;
            w_pc_nxt       = '0;
          end else begin
            w_load_adr_nxt = r_load_adr + PC_WIDTH'(1);
          end
        end else if (run) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_pc_nxt    = cnt_wr_en ? literal_adr : r_pc + PC_WIDTH'(1);
        w_state_nxt = run ? S_FETCH : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_load_adr <= '0;
      r_instr    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_load_adr <= w_load_adr_nxt;
      if (r_state == S_FETCH) begin
        r_instr <= r_mem[r_pc];
      end
    end
  end

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_load_adr] <= load_data;
    end
  end

  assign instruction = (r_state == S_EXEC) ? r_instr : '0;
  assign instr_valid = (r_state == S_EXEC);
  assign load_ready  = (r_state == S_IDLE);
  assign halted      = (r_state == S_IDLE);
  assign pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-instruction transaction model (memory image, pc, load address)
// driven with directed sequences plus randomized program words, jumps, halts and stray loads.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic        cnt_wr_en;
  logic [7:0]  literal_adr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  int checks;
  int failures;

  logic [15:0] m_mem [256];
  logic [7:0]  m_pc;
  logic [7:0]  m_ladr;

  instr_fetch #(
    .PC_WIDTH         (8),
    .PROGRAM_DataWidth(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .cnt_wr_en  (cnt_wr_en),
    .literal_adr(literal_adr),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with load_valid low.
  task automatic load_word(input logic [15:0] data, input bit last, input bit run_too);
    chk("load_ready_idle", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    run        = run_too;
    @(posedge clk);
    m_mem[m_ladr] = data;
    if (last) begin
      m_ladr = 8'd0;
      m_pc   = 8'd0;
    end else begin
      m_ladr = m_ladr + 8'd1;
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    run        = 1'b0;
    chk("load_stays_idle", 32'(halted), 32'd1);
  endtask

  // One FETCH+EXEC pair. Entered at a negedge just before the edge into FETCH, returns at the
  // negedge inside EXEC with the jump and run decision for the closing edge already driven.
  task automatic do_instr(input bit run_f, input bit jump, input logic [7:0] tgt,
                          input bit run_e, input bit poke);
    @(posedge clk);
    @(negedge clk);
    chk("fetch_valid", 32'(instr_valid), 32'd0);
    chk("fetch_instr", 32'(instruction), 32'd0);
    chk("fetch_ready", 32'(load_ready), 32'd0);
    chk("fetch_halted", 32'(halted), 32'd0);
    chk("fetch_pc", 32'(pc), 32'(m_pc));
    run         = run_f;
    cnt_wr_en   = 1'($urandom);
    literal_adr = 8'($urandom);
    if (poke) begin
      load_valid = 1'b1;
      load_data  = 16'($urandom);
      load_last  = 1'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_instr", 32'(instruction), 32'(m_mem[m_pc]));
    chk("exec_pc", 32'(pc), 32'(m_pc));
    chk("exec_ready", 32'(load_ready), 32'd0);
    chk("exec_halted", 32'(halted), 32'd0);
    run         = run_e;
    cnt_wr_en   = jump;
    literal_adr = tgt;
    load_valid  = 1'b0;
    load_last   = 1'b0;
    m_pc        = jump ? tgt : m_pc + 8'd1;
  endtask

  // Follows a do_instr with run_e=0; leaves the core halted, then arms run=1 for a restart.
  task automatic check_idle(input bit rearm);
    @(posedge clk);
    @(negedge clk);
    chk("idle_halted", 32'(halted), 32'd1);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    chk("idle_instr", 32'(instruction), 32'd0);
    chk("idle_ready", 32'(load_ready), 32'd1);
    chk("idle_pc", 32'(pc), 32'(m_pc));
    cnt_wr_en   = 1'b1;
    literal_adr = 8'($urandom);
    run         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_pc_hold", 32'(pc), 32'(m_pc));
    cnt_wr_en = 1'b0;
    run       = rearm;
  endtask

  initial begin
    bit halt;
    checks      = 0;
    failures    = 0;
    m_pc        = 8'd0;
    m_ladr      = 8'd0;
    rst_n       = 1'b1;
    run         = 1'b0;
    load_valid  = 1'b0;
    load_data   = 16'd0;
    load_last   = 1'b0;
    cnt_wr_en   = 1'b0;
    literal_adr = 8'd0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_release_ready", 32'(load_ready), 32'd1);

    // Directed program; first word loaded with run high (load wins)
    load_word(16'h0910, 1'b0, 1'b1);
    load_word(16'h2B18, 1'b0, 1'b0);
    load_word(16'h8000, 1'b1, 1'b0);
    run = 1'b1;
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(1'b0);
    chk("fallthrough_pc", 32'(pc), 32'h03);

    // Full 256-word random program, run across the pc wrap with stray loads
    for (int i = 0; i < 256; i++) begin
      load_word(16'($urandom), i == 255, ($urandom % 4) == 0);
    end
    run = 1'b1;
    for (int i = 0; i < 258; i++) begin
      do_instr(1'b1, 1'b0, 8'h00, 1'b1, ($urandom % 4) == 0);
    end
    // run dropped during FETCH: EXEC completes, then halt and resume at retained pc
    do_instr(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(1'b1);
    for (int i = 0; i < 60; i++) begin
      halt = ($urandom % 8) == 0;
      do_instr(halt ? 1'($urandom) : 1'b1, ($urandom % 6) == 0, 8'($urandom), !halt,
               ($urandom % 4) == 0);
      if (halt) check_idle(1'b1);
    end
    do_instr(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(1'b0);

    // Load address wrap: 257 plain writes then a final word, read back from address 0
    for (int i = 0; i < 257; i++) begin
      load_word(16'($urandom), 1'b0, 1'b0);
    end
    load_word(16'($urandom), 1'b1, 1'b0);
    run = 1'b1;
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(1'b0);

    // Asynchronous reset in the middle of an EXEC cycle
    load_word(16'h0910, 1'b0, 1'b0);
    load_word(16'h2B18, 1'b0, 1'b0);
    load_word(16'h8000, 1'b1, 1'b0);
    run = 1'b1;
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_instr(1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    m_pc   = 8'd0;
    m_ladr = 8'd0;
    chk("async_rst_instr", 32'(instruction), 32'd0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("async_rst_halted", 32'(halted), 32'd1);
    run       = 1'b0;
    cnt_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("async_rst_ready", 32'(load_ready), 32'd1);
    run = 1'b1;
    do_instr(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rerun_first_word", 32'(instruction), 32'h0910);
    do_instr(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-side front end of the 8-bit CPU: holds program memory, the program counter and the instruction register, and produces the 16-bit `instruction` word consumed by `decoder`.
- Closes the loop with `decoder`: takes back `cnt_wr_en` and `literal_adr` to redirect the PC on GOTO/IF* jumps.
- Provides a valid/ready load port for writing the program while the core is halted.

Parameters:
- PC_WIDTH, 8, program counter / program memory address width (2^PC_WIDTH words).
- PROGRAM_DataWidth, 16, instruction word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = execute program, 0 = halt after current instruction.
- load_valid  in  1  load word present on load_data.
- load_ready  out  1  block accepts a load word this cycle.
- load_data  in  PROGRAM_DataWidth  program word to write.
- load_last  in  1  qualifies the final load word of a program.
- cnt_wr_en  in  1  from decoder: take jump this instruction.
- literal_adr  in  PC_WIDTH  from decoder: jump target.
- instruction  out  PROGRAM_DataWidth  to decoder; fetched word in EXEC, 16'h0000 (NOP) otherwise.
- instr_valid  out  1  high exactly during EXEC.
- pc  out  PC_WIDTH  current program counter.
- halted  out  1  high in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, load_adr=0, instr_reg=0.
  - Outputs: instruction=0, instr_valid=0, halted=1, load_ready=1 once rst_n releases.
  - Program memory contents are not reset.
- Program memory: 2^PC_WIDTH x PROGRAM_DataWidth, one write port (load), synchronous read (FETCH).
- States: IDLE, FETCH, EXEC.
- IDLE:
  - load_ready=1.
  - On load_valid: mem[load_adr] <= load_data; load_adr++ (wraps 2^PC_WIDTH-1 -> 0).
  - load_valid with load_last: write as above, then load_adr <= 0 and pc <= 0.
  - run=1 and load_valid=0: go to FETCH.
  - run=1 and load_valid=1 in the same cycle: the load wins; stay IDLE.
- FETCH:
  - instr_reg <= mem[pc]; go to EXEC.
  - instruction=0, instr_valid=0, load_ready=0.
- EXEC:
  - instruction=instr_reg, instr_valid=1; the decoder responds combinationally.
  - At the clock edge, pc <= cnt_wr_en ? literal_adr : pc+1 (PC_WIDTH-bit, wraps 0xFF -> 0x00).
  - Next state: FETCH if run=1, else IDLE.
  - cnt_wr_en and literal_adr are ignored in all other states.
- Throughput: one instruction per 2 cycles. The rising edge of run to the first instr_valid is 2 cycles.
- Outside EXEC the instruction output is forced to NOP, so decoder-driven write enables pulse once per instruction.
- run dropped during FETCH: EXEC still completes, then IDLE. pc is retained and a later run resumes from pc.
- load_valid outside IDLE: ignored (load_ready=0); nothing is written.
- halted = (state==IDLE).
- Reset asserted mid-FETCH or mid-EXEC: outputs take reset values immediately; no partial PC update.

Test Plan:
1. Reset: hold rst_n=0 -> instruction=0x0000, instr_valid=0, pc=0x00, halted=1. Release -> load_ready=1.
2. Load and run:
   - Load 0x0910 (ADD r1,r2), 0x2B18 (AND r3,r2), 0x8000 (GOTO 0x00); load_last on the third word.
   - Assert run.
   - instr_valid pulses on alternate cycles with instruction 0x0910, 0x2B18, 0x8000 and pc 0,1,2.
   - instruction=0x0000 between pulses.
3. Jump: in the EXEC of 0x8000 drive cnt_wr_en=1, literal_adr=0x00 -> next pc=0x00; the next instruction is 0x0910. With cnt_wr_en=0 the next pc is 0x03.
4. Wrap:
   - Load 256 NOPs ending with load_last; run -> pc counts 0xFF -> 0x00; no X on outputs.
   - Load wrap: 257 writes without load_last -> load_adr=0x01 and mem[0x00] holds the 257th word.
5. Halt and ignore:
   - Drop run during FETCH -> one more EXEC, then halted=1 with pc=next address.
   - load_valid pulsed while running -> load_ready=0; memory unchanged, verified by a later readback run.
   - Re-assert run -> execution resumes at the retained pc.
6. Async reset in EXEC with instr_valid=1: pull rst_n low mid-cycle -> instruction=0 and pc=0 without waiting for a clock edge. After release, run re-executes the program from 0x0910 (memory retained).
